// File: rtl/alu_mp_seq_pkg.sv
// Shared types and constants for the multi-precision alu sequencer.
// FSM state encoding, alu status bit positions, and the alu opcodes
// used by integration benches.
package alu_mp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit positions inside the alu Status vector {CF,ZF,NF,VF,PF,AF}
   localparam int CF_IDX = 5;
   localparam int ZF_IDX = 4;
   localparam int NF_IDX = 3;
   localparam int VF_IDX = 2;
   localparam int PF_IDX = 1;
   localparam int AF_IDX = 0;

   // alu F decode for the two carry-chaining operations
   localparam logic [4:0] ALU_OP_ADD = 5'd0;
   localparam logic [4:0] ALU_OP_SUB = 5'd1;

endpackage

// File: rtl/alu_mp_seq.sv
// Multi-precision operation sequencer feeding an external combinational
// 16-bit alu one word per cycle, LS word first, with optional CF->Cin
// chaining and aggregated status.
// Optional build: ALU_MP_BYPASS_EN lets a new operation be accepted on the
// same edge the finished result is consumed (no IDLE bubble).
module alu_mp_seq
   import alu_mp_pkg::*;
#(
   parameter int WORDS = 2,
   parameter int LEN_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   op_a,
   input  logic [16*WORDS-1:0]   op_b,
   input  logic [4:0]            op_f,
   input  logic                  op_cin,
   input  logic                  op_chain,
   input  logic [LEN_W-1:0]      op_len,
   output logic [15:0]           alu_a,
   output logic [15:0]           alu_b,
   output logic [4:0]            alu_f,
   output logic                  alu_cin,
   input  logic [15:0]           alu_result,
   input  logic [5:0]            alu_status,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   out_result,
   output logic [5:0]            out_status
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORDS - 1);

   state_t                        state;
   logic [WORDS-1:0][15:0]        a_q, b_q, res_q, res_nxt;
   logic [4:0]                    f_q;
   logic                          cin_q, chain_q;
   logic [LEN_W-1:0]              len_q, idx_q;
   logic                          carry_q, zf_acc, pf_q, af_q;
   logic [15:0]                   cur_a, cur_b;
   logic [1:0]                    pf_af;
   logic [5:0]                    status_nxt;
   logic                          accept;
   logic                          exec;

   assign exec = (state == EXEC);

   // Ready only while reset is released; DONE may also accept in the bypass build
`ifdef ALU_MP_BYPASS_EN
   assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
`else
   assign in_ready = rst_n & (state == IDLE);
`endif
   assign accept = in_valid & in_ready;

   // Select the current word and fold the alu result into the working buffer
   always_comb begin
      cur_a   = '0;
      cur_b   = '0;
      res_nxt = res_q;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == LEN_W'(i)) begin
            cur_a      = a_q[i];
            cur_b      = b_q[i];
            res_nxt[i] = alu_result;
         end
      end
   end

   // Final flags: CF/NF/VF from the top word, ZF over all words, PF/AF from word 0
   always_comb begin
      pf_af      = (idx_q == '0) ? {alu_status[PF_IDX], alu_status[AF_IDX]} : {pf_q, af_q};
      status_nxt = {alu_status[CF_IDX], zf_acc & alu_status[ZF_IDX],
                    alu_status[NF_IDX], alu_status[VF_IDX], pf_af};
   end

   // alu drive is forced to zero whenever no word is being executed
   always_comb begin
      alu_a   = exec ? cur_a : 16'h0;
      alu_b   = exec ? cur_b : 16'h0;
      alu_f   = exec ? f_q   : 5'h0;
      alu_cin = exec ? (((idx_q == '0) || !chain_q) ? cin_q : carry_q) : 1'b0;
   end

   // Sequencer FSM: latch request, walk words, hold result until consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         f_q        <= '0;
         cin_q      <= 1'b0;
         chain_q    <= 1'b0;
         len_q      <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         zf_acc     <= 1'b0;
         pf_q       <= 1'b0;
         af_q       <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_status <= '0;
      end else if (accept) begin
         a_q       <= op_a;
         b_q       <= op_b;
         f_q       <= op_f;
         cin_q     <= op_cin;
         chain_q   <= op_chain;
         len_q     <= (op_len > MAX_LEN) ? MAX_LEN : op_len;
         res_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         zf_acc    <= 1'b1;
         out_valid <= 1'b0;
         state     <= EXEC;
      end else begin
         case (state)
            EXEC: begin
               res_q   <= res_nxt;
               carry_q <= alu_status[CF_IDX];
               zf_acc  <= zf_acc & alu_status[ZF_IDX];
               if (idx_q == '0) begin
                  pf_q <= alu_status[PF_IDX];
                  af_q <= alu_status[AF_IDX];
               end
               if (idx_q == len_q) begin
                  out_result <= res_nxt;
                  out_status <= status_nxt;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx_q <= idx_q + LEN_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
